// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the FSM state type, default geometry, key-code width and column priority encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam int DEF_ROWS          = 4;
    localparam int DEF_COLS          = 4;
    localparam int DEF_DWELL         = 4;
    localparam int DEF_DEBOUNCE_CNT  = 10;
    localparam int DEF_REPEAT_DELAY  = 500;
    localparam int DEF_REPEAT_PERIOD = 100;

    // Widest column bus the priority encoder accepts.
    localparam int MAX_COLS = 32;

    function automatic int code_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int lowest_col(input logic [MAX_COLS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_COLS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key event handshake between the keypad scanner and its consumer.
// master: key_code/key_valid/key_held out, key_ack in; slave: the mirror.
interface keypad_scan_ctrl_if
    import keypad_pkg::*;
#(
    parameter int KW = code_w(DEF_ROWS, DEF_COLS)
);
    logic [KW-1:0] key_code;
    logic          key_valid;
    logic          key_ack;
    logic          key_held;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        output key_ack
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of asynchronous inputs.
// Ports: clk, reset_n, rst_val_i (value loaded on reset), d_i (async in), q_o (synced out).
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] rst_val_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= rst_val_i;
            sync_q <= rst_val_i;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning matrix keypad controller with shared debounce and one event per press.
// Ports: clk, reset_n (async, active-low), col_n (raw active-low columns),
//   row_n (one-hot active-low row drive), kif (master: key_code/key_valid/key_held, key_ack).
// Optional macro KEYPAD_AUTOREPEAT_EN adds hold-to-repeat events.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DWELL        = DEF_DWELL,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COLS-1:0]    col_n,
    output logic [ROWS-1:0]    row_n,
    keypad_scan_ctrl_if.master kif
);
    localparam int KW = code_w(ROWS, COLS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(DWELL);
    localparam int NW = $clog2(DEBOUNCE_CNT + 1);

    state_t          state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [DW-1:0]   dw_q;
    logic [NW-1:0]   cnt_q;
    logic [ROWS-1:0] row_n_q;
    logic [KW-1:0]   code_q;
    logic            valid_q;
    logic            held_q;

    logic [COLS-1:0] col_sync;
    logic [COLS-1:0] colsync;
    logic [RW-1:0]   row_d;
    logic [CW-1:0]   col_d;
    logic [NW-1:0]   cnt_d;
    logic [KW-1:0]   code_d;
    logic            hit;
    logic            slot_free;

    sync_2ff #(
        .W(COLS)
    ) u_col_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .rst_val_i({COLS{1'b1}}),
        .d_i      (col_n),
        .q_o      (col_sync)
    );

    assign colsync = ~col_sync;
    assign hit     = colsync[col_q];
    assign row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    assign col_d   = CW'(lowest_col(MAX_COLS'(colsync)));
    assign cnt_d   = (cnt_q == NW'(DEBOUNCE_CNT)) ? cnt_q : cnt_q + NW'(1);
    assign code_d  = KW'(row_q) * KW'(COLS) + KW'(col_q);
    // An ack on the same edge frees the slot for a new event.
    assign slot_free = !valid_q || kif.key_ack;

    function automatic logic [ROWS-1:0] drive(input logic [RW-1:0] r);
        return ~(ROWS'(1) << r);
    endfunction

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rep_q;
    logic           first_q;
    logic           rep_due;

    assign rep_due = first_q ? (rep_q == RPW'(REPEAT_DELAY - 1))
                             : (rep_q == RPW'(REPEAT_PERIOD - 1));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
            row_q   <= '0;
            col_q   <= '0;
            dw_q    <= '0;
            cnt_q   <= '0;
            row_n_q <= '1;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
            first_q <= 1'b1;
`endif
        end else begin
            if (valid_q && kif.key_ack) valid_q <= 1'b0;
            unique case (state_q)
                SCAN: begin
                    if (dw_q == DW'(DWELL - 1)) begin
                        dw_q <= '0;
                        if (|colsync) begin
                            state_q <= DEBOUNCE;
                            col_q   <= col_d;
                            cnt_q   <= '0;
                        end else begin
                            row_q   <= row_d;
                            row_n_q <= drive(row_d);
                        end
                    end else begin
                        dw_q    <= dw_q + DW'(1);
                        row_n_q <= drive(row_q);
                    end
                end
                DEBOUNCE: begin
                    if (!hit) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        dw_q    <= '0;
                        row_q   <= row_d;
                        row_n_q <= drive(row_d);
                    end else if (cnt_q == NW'(DEBOUNCE_CNT - 1)) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                        // A still-pending older event wins; this press is dropped.
                        if (slot_free) begin
                            valid_q <= 1'b1;
                            code_q  <= code_d;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_q   <= '0;
                        first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HELD: begin
                    if (!hit && cnt_q == NW'(DEBOUNCE_CNT - 1)) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                        dw_q    <= '0;
                        row_q   <= row_d;
                        row_n_q <= drive(row_d);
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_q   <= '0;
                        first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= hit ? '0 : cnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_due) begin
                            rep_q   <= '0;
                            first_q <= 1'b0;
                            if (slot_free) begin
                                valid_q <= 1'b1;
                                code_q  <= code_d;
                            end
                        end else begin
                            rep_q <= rep_q + RPW'(1);
                        end
`endif
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign row_n         = row_n_q;
    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign kif.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed bench for keypad_scan_ctrl with a timestamp-based keypad model.
// Also exercises KEYPAD_AUTOREPEAT_EN when that macro is defined.
module tb_keypad_scan_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DWELL = 4;
    localparam int DBC = 10;
    localparam int RDLY = 500;
    localparam int RPER = 100;

    logic            clk;
    logic            reset_n;
    logic [COLS-1:0] col_n;
    logic [ROWS-1:0] row_n;
    logic [ROWS-1:0][COLS-1:0] press;

    keypad_scan_ctrl_if #(.KW(4)) kif();

    keypad_scan_ctrl dut (
        .clk    (clk),
        .reset_n(reset_n),
        .col_n  (col_n),
        .row_n  (row_n),
        .kif    (kif)
    );

    // Physical keypad: a pressed key shorts its column to the driven-low row.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_n[r] && press[r][c]) col_n[c] = 1'b0;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: times measured in clock edges since reset.
    int cyc, t_mark, t_conf, m_phase, m_row, m_col;
    logic [COLS-1:0] s1, s2;
    logic m_valid, m_held;
    logic [3:0] m_code;
    logic [3:0] m_rown;

    task automatic model_reset();
        cyc = 0; t_mark = 0; t_conf = 0; m_phase = 0;
        m_row = 0; m_col = 0;
        s1 = '1; s2 = '1;
        m_valid = 0; m_held = 0; m_code = 0;
        m_rown = 4'b1111;
    endtask

    task automatic raise_event();
        if (!m_valid) begin
            m_valid = 1;
            m_code = 4'(m_row * COLS + m_col);
        end
    endtask

    task automatic model_step(input logic [COLS-1:0] cn, input logic ack);
        logic [COLS-1:0] cs;
        cs = ~s2;
        s2 = s1;
        s1 = cn;
        cyc++;
        if (m_valid && ack) m_valid = 0;
        if (m_phase == 0) begin
            if (cyc - t_mark == DWELL) begin
                t_mark = cyc;
                if (cs != 0) begin
                    m_phase = 1;
                    for (int c = COLS - 1; c >= 0; c--) if (cs[c]) m_col = c;
                end else begin
                    m_row = (m_row + 1) % ROWS;
                end
            end
        end else if (m_phase == 1) begin
            if (!cs[m_col]) begin
                m_phase = 0; t_mark = cyc; m_row = (m_row + 1) % ROWS;
            end else if (cyc - t_mark == DBC) begin
                m_phase = 2; m_held = 1; t_mark = cyc; t_conf = cyc;
                raise_event();
            end
        end else begin
            if (cs[m_col]) t_mark = cyc;
            if (!cs[m_col] && cyc - t_mark == DBC) begin
                m_phase = 0; m_held = 0; t_mark = cyc; m_row = (m_row + 1) % ROWS;
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                if (cyc - t_conf >= RDLY && (cyc - t_conf - RDLY) % RPER == 0)
                    raise_event();
`endif
            end
        end
        m_rown = ~(4'b0001 << m_row);
    endtask

    // Compare process: model steps on every edge, outputs checked 1 time unit later.
    initial begin
        logic [COLS-1:0] cn;
        logic ak;
        model_reset();
        forever begin
            @(posedge clk);
            cn = col_n;
            ak = kif.key_ack;
            if (!reset_n) model_reset();
            else model_step(cn, ak);
            #1;
            check("row_n", row_n, m_rown);
            check("key_valid", kif.key_valid, m_valid);
            check("key_held", kif.key_held, m_held);
            check("key_code", kif.key_code, m_code);
        end
    end

    task automatic wait_sig(input string nm, input int sel, input logic [31:0] val, input int max);
        bit hit;
        hit = 0;
        for (int i = 0; i < max && !hit; i++) begin
            @(posedge clk);
            #1;
            case (sel)
                0: hit = (kif.key_valid == val[0]);
                1: hit = (kif.key_held == val[0]);
                default: hit = (row_n == val[3:0]);
            endcase
        end
        check(nm, 32'(hit), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        press = '0;
        kif.key_ack = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        kif.key_ack = 1;
        @(negedge clk);
        kif.key_ack = 0;
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_EV = 4;
`else
    localparam int EXP_EV = 1;
`endif

    initial begin
        bit seen;
        bit lastv;
        int nev;
        int tq[$];
        reset_n = 0;
        press = '0;
        kif.key_ack = 0;

        // Reset values and first drive
        @(posedge clk);
        #1;
        check("rst_row_n", row_n, 4'b1111);
        check("rst_valid", kif.key_valid, 0);
        check("rst_held", kif.key_held, 0);
        check("rst_code", kif.key_code, 0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        check("first_row", row_n, 4'b1110);

        // Random presses, multi-key, bounce and acks
        for (int e = 0; e < 45; e++) begin
            int kind, len, r0, c0, r1, c1;
            kind = $urandom_range(0, 3);
            len = $urandom_range(5, 80);
            r0 = $urandom_range(0, ROWS - 1);
            c0 = $urandom_range(0, COLS - 1);
            r1 = $urandom_range(0, ROWS - 1);
            c1 = $urandom_range(0, COLS - 1);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                press = '0;
                case (kind)
                    1: press[r0][c0] = 1'b1;
                    2: begin
                        press[r0][c0] = 1'b1;
                        press[r1][c1] = 1'b1;
                    end
                    3: press[r0][c0] = ($urandom_range(0, 2) != 0);
                    default: ;
                endcase
                kif.key_ack = ($urandom_range(0, 5) == 0);
            end
        end
        @(negedge clk);
        press = '0;
        kif.key_ack = 0;
        repeat (30) @(negedge clk);

        // Clean press row 2 col 1, unacked event holds, then one ack
        do_reset();
        press[2][1] = 1'b1;
        wait_sig("press_valid", 0, 1, 100);
        check("press_code", kif.key_code, 9);
        check("press_held", kif.key_held, 1);
        repeat (50) @(posedge clk);
        #1;
        check("valid_hold50", kif.key_valid, 1);
        ack_pulse();
        check("valid_after_ack", kif.key_valid, 0);
        press = '0;
        wait_sig("release_held", 1, 0, 50);

        // Reset while debouncing row 2
        do_reset();
        press[2][1] = 1'b1;
        wait_sig("reach_row2", 2, 4'b1011, 50);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset_n = 0;
        #1;
        check("midrst_row_n", row_n, 4'b1111);
        check("midrst_valid", kif.key_valid, 0);
        check("midrst_held", kif.key_held, 0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        check("midrst_first_row", row_n, 4'b1110);
        @(negedge clk);
        press = '0;

        // Bounce on row 2 col 1: never confirmed
        do_reset();
        wait_sig("bounce_row2", 2, 4'b1011, 50);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            press[2][1] = ((i / 3) % 2 == 0);
            if (kif.key_valid || kif.key_held) seen = 1;
        end
        @(negedge clk);
        press = '0;
        check("bounce_no_event", 32'(seen), 0);
        wait_sig("bounce_row3", 2, 4'b0111, 40);

        // Two keys on row 1: lowest column wins
        do_reset();
        press[1][0] = 1'b1;
        press[1][3] = 1'b1;
        wait_sig("two_valid", 0, 1, 100);
        check("two_code", kif.key_code, 4);
        ack_pulse();
        press = '0;
        wait_sig("two_release", 1, 0, 50);

        // Release glitch on row 0 col 2
        do_reset();
        press[0][2] = 1'b1;
        wait_sig("glitch_held", 1, 1, 100);
        ack_pulse();
        @(negedge clk);
        press = '0;
        repeat (6) @(negedge clk);
        press[0][2] = 1'b1;
        @(negedge clk);
        press = '0;
        repeat (11) @(posedge clk);
        #1;
        check("glitch_still_held", kif.key_held, 1);
        @(posedge clk);
        #1;
        check("glitch_released", kif.key_held, 0);
        check("glitch_next_row", row_n, 4'b1101);

        // Long hold of key 5, acking every event
        do_reset();
        press[1][1] = 1'b1;
        nev = 0;
        lastv = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            kif.key_ack = kif.key_valid;
            @(posedge clk);
            #1;
            if (kif.key_valid && !lastv) begin
                nev++;
                tq.push_back(i);
                check("hold_code", kif.key_code, 5);
            end
            lastv = kif.key_valid;
        end
        @(negedge clk);
        kif.key_ack = 0;
        press = '0;
        check("hold_events", nev, EXP_EV);
`ifdef KEYPAD_AUTOREPEAT_EN
        if (tq.size() >= 4) begin
            check("rep_first", tq[1] - tq[0], RDLY);
            check("rep_second", tq[2] - tq[1], RPER);
            check("rep_third", tq[3] - tq[2], RPER);
        end
`endif
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scans a ROWS x COLS matrix keypad, one row at a time, and debounces the detected key. It emits one encoded key event per debounced press through a valid/ack handshake. It sits between the board keypad pins and the user-input logic and runs on the same 1 kHz system clock as the single-input debounce logic. One debounce counter is shared across all keys, and the FSM sequences it.

Parameters:
ROWS, 4, number of row lines driven (>=2)
COLS, 4, number of column lines sampled (>=2)
DWELL, 4, cycles each row is driven before columns are sampled (>=3; covers 2-FF sync plus settle)
DEBOUNCE_CNT, 10, consecutive identical samples required to confirm a press or a release (10 ms at 1 kHz)
REPEAT_DELAY, 500, cycles of hold before the first auto-repeat (used only with the optional feature)
REPEAT_PERIOD, 100, cycles between auto-repeats (used only with the optional feature)

Ports:
clk  input  1  system clock, 1 kHz
reset_n  input  1  asynchronous active-low reset
col_n  input  COLS  raw asynchronous column lines, active-low (key pressed = 0)
row_n  output  ROWS  row drive, one-hot active-low
key_code  output  $clog2(ROWS*COLS)  encoded key, equal to row*COLS+col
key_valid  output  1  key event pending
key_ack  input  1  consumer accepts the event
key_held  output  1  a debounced key is currently down

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, reset_n. All flops clear on reset assertion.
- Reset values: row_n = all ones, key_code = 0, key_valid = 0, key_held = 0. Internal state is SCAN with row index 0 and all counters 0.
- First cycle after reset deassertion: row_n drives row 0 low (row_n = 4'b1110 at defaults).
- Column synchronizer: col_n passes through a 2-FF synchronizer; colsync is the active-high inverted result. Sync flops reset to "no key".
- SCAN state:
  - Each row is driven for DWELL cycles; colsync is sampled on the last dwell cycle.
  - If no column is active, advance to row+1, wrapping from ROWS-1 to 0.
  - If any column is active, capture row r and the lowest-index active column c, then go to DEBOUNCE. row_n stays on r.
- DEBOUNCE state:
  - Each cycle, if colsync[c] = 1, increment cnt; otherwise return to SCAN at row r+1 with cnt = 0.
  - When cnt reaches DEBOUNCE_CNT-1 with colsync[c] still 1, go to HELD on the next edge. On that edge key_valid = 1, key_code = r*COLS+c and key_held = 1.
- HELD state:
  - row_n stays on r.
  - A release counter counts consecutive cycles with colsync[c] = 0. Any 1 clears it.
  - At DEBOUNCE_CNT consecutive zeros: key_held = 0, return to SCAN at row r+1.
  - Other keys are ignored while HELD.
- Handshake:
  - key_valid stays high and key_code stays stable until a clk edge samples key_ack = 1. key_valid is 0 from the next cycle.
  - key_ack while key_valid = 0 is ignored.
  - key_valid is independent of release. A pending event survives release and is not overwritten.
  - SCAN may detect and debounce a new press while key_valid is still 1. The new event is dropped: key_held still asserts, but key_code is unchanged.
  - If confirmation and ack occur on the same edge, the ack clears the old event and the new event is then presented (key_valid = 1, new key_code).
- Width rules:
  - cnt is $clog2(DEBOUNCE_CNT+1) bits and saturates; it never wraps.
  - The dwell counter is $clog2(DWELL) bits.
  - key_code multiplication is evaluated in key_code width.
- Reset mid-operation: returns immediately to the reset values above, from any state. No event is emitted.

Optional Feature:
Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, a repeat counter starts at press confirmation.
  - After REPEAT_DELAY cycles, and then every REPEAT_PERIOD cycles, a new key_valid event with the same key_code is raised if key_valid = 0.
  - If key_valid = 1 at that point, the repeat is dropped and the counter continues.
  - The counter clears on release.
- Undefined: exactly one event per press; REPEAT_DELAY and REPEAT_PERIOD are unused.

Decomposition:
- Package keypad_pkg:
  - state enum typedef (SCAN, DEBOUNCE, HELD)
  - default localparams for ROWS, COLS, DWELL, DEBOUNCE_CNT
  - key_code width function
- One sub-module: sync_2ff, a parameterised-width 2-flop synchronizer with reset value input, instantiated for col_n.
- The lowest-index column priority encoder stays inline as a function in the package.

Test Plan:
- Reset: pull reset_n low while in DEBOUNCE with row 2 driven -> row_n = 4'b1111, key_valid = 0, key_held = 0 immediately. After release -> row_n = 4'b1110 on the next cycle.
- Clean press of row 2, col 1 held 40 cycles, key_ack = 0 -> key_valid = 1 with key_code = 9, key_held = 1. key_valid is held for 50 cycles. One key_ack pulse -> key_valid = 0 on the next cycle.
- Bounce: col 1 toggles every 3 cycles for 30 cycles while row 2 is driven -> no key_valid, and the scan continues to row 3.
- Two keys, row 1 col 0 and row 1 col 3, both pressed -> key_code = 4.
- Release glitch: while HELD, col released 6 cycles, re-pressed 1 cycle, then released -> key_held stays 1 until 10 clean released cycles, then 0 and the scan resumes at the next row.
- KEYPAD_AUTOREPEAT_EN: hold key 5 for 800 cycles, acking each event -> events at confirmation, +500, +600, +700 cycles, all with key_code = 5. Not defined: exactly one event.
